// File: rtl/unpool2_streamer_if.sv
// Map-in / row-out handshake bundle for the 2x2 unpooling streamer.
// slave is the streamer's view, master is the surrounding logic.
interface unpool2_streamer_if;
  logic          i_map_valid;
  logic          o_map_ready;
  logic [0:15]   i_map;
  logic          o_row_valid;
  logic          i_row_ready;
  logic [0:7]    o_row;
  logic [2:0]    o_row_idx;
  logic          o_row_last;
  logic          o_busy;

  modport slave (
    input  i_map_valid, i_map, i_row_ready,
    output o_map_ready, o_row_valid, o_row,
    output o_row_idx, o_row_last, o_busy
  );

  modport master (
    output i_map_valid, i_map, i_row_ready,
    input  o_map_ready, o_row_valid, o_row,
    input  o_row_idx, o_row_last, o_busy
  );
endinterface

// File: rtl/unpool2_streamer.sv
// 4x4 binary map -> 8x8 nearest-neighbour upsampler, one row per beat.
// Active slot streams while a pending slot buffers the next map.
module unpool2_streamer (
  input  logic                 clk,
  input  logic                 rst_n,
  unpool2_streamer_if.slave    bus
);

  typedef enum logic {
    EMPTY,
    STREAM
  } state_e;

  state_e      state_q;
  logic [0:15] active_q;
  logic [0:15] pend_q;
  logic        pend_full_q;
  logic        pend_full_d;
  logic        ready_q;
  logic [2:0]  idx_q;

  logic        valid;
  logic        last;
  logic        map_hs;
  logic        row_hs;
  logic [0:7]  row;

  assign valid  = (state_q == STREAM);
  assign last   = (idx_q == 3'd7);
  assign map_hs = bus.i_map_valid && ready_q;
  assign row_hs = valid && bus.i_row_ready;

  // pending drains on the last-row beat, so no refill in that cycle
  always_comb begin
    pend_full_d = pend_full_q;
    if (pend_full_q) begin
      if (row_hs && last) pend_full_d = 1'b0;
    end else if (valid && map_hs && !(row_hs && last)) begin
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    row = '0;
    for (int c = 0; c < 8; c++) begin
      row[c] = active_q[{idx_q[2:1], 2'(c / 2)}];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b0;
      idx_q       <= '0;
    end else begin
      pend_full_q <= pend_full_d;
      ready_q     <= !pend_full_d;
      unique case (state_q)
        EMPTY: begin
          if (map_hs) begin
            active_q <= bus.i_map;
            idx_q    <= '0;
            state_q  <= STREAM;
          end
        end
        STREAM: begin
          if (row_hs && last) begin
            idx_q <= '0;
            if (pend_full_q) begin
              active_q <= pend_q;
              pend_q   <= '0;
            end else if (map_hs) begin
              active_q <= bus.i_map;
            end else begin
              state_q <= EMPTY;
            end
          end else begin
            if (row_hs) idx_q <= idx_q + 3'd1;
            if (map_hs) pend_q <= bus.i_map;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign bus.o_map_ready = ready_q;
  assign bus.o_row_valid = valid;
  assign bus.o_row       = valid ? row : '0;
  assign bus.o_row_idx   = idx_q;
  assign bus.o_row_last  = valid && last;
  assign bus.o_busy      = valid || pend_full_q;

endmodule

// File: tb/tb_unpool2_streamer.sv
// Directed bench for unpool2_streamer: single map, back-to-back,
// backpressure, pending-full, simultaneous load and mid-stream reset.
module tb_unpool2_streamer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  unpool2_streamer_if bus ();

  unpool2_streamer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp1 [8];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp1 = '{8'hC0, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h03};
    rst_n = 1'b0;
    bus.i_map_valid = 1'b0;
    bus.i_map = '0;
    bus.i_row_ready = 1'b0;

    // reset state
    step();
    step();
    chk("rst_valid", 32'(bus.o_row_valid), 32'h0);
    chk("rst_ready", 32'(bus.o_map_ready), 32'h0);
    chk("rst_busy", 32'(bus.o_busy), 32'h0);
    chk("rst_row", 32'(bus.o_row), 32'h0);
    chk("rst_idx", 32'(bus.o_row_idx), 32'h0);
    chk("rst_last", 32'(bus.o_row_last), 32'h0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(bus.o_map_ready), 32'h1);
    chk("post_rst_valid", 32'(bus.o_row_valid), 32'h0);

    // single map, corners set
    bus.i_row_ready = 1'b1;
    bus.i_map = 16'h8001;
    bus.i_map_valid = 1'b1;
    step();
    bus.i_map_valid = 1'b0;
    for (int r = 0; r < 8; r++) begin
      chk("t1_valid", 32'(bus.o_row_valid), 32'h1);
      chk("t1_idx", 32'(bus.o_row_idx), 32'(r));
      chk("t1_row", 32'(bus.o_row), 32'(exp1[r]));
      chk("t1_last", 32'(bus.o_row_last), 32'(r == 7));
      step();
    end
    chk("t1_end_valid", 32'(bus.o_row_valid), 32'h0);
    chk("t1_end_busy", 32'(bus.o_busy), 32'h0);

    // back-to-back all-ones then all-zeros
    bus.i_map = 16'hFFFF;
    bus.i_map_valid = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      if (k == 0) bus.i_map = 16'h0000;
      if (k == 1) bus.i_map_valid = 1'b0;
      chk("t2_valid", 32'(bus.o_row_valid), 32'h1);
      chk("t2_idx", 32'(bus.o_row_idx), 32'(k % 8));
      chk("t2_row", 32'(bus.o_row), (k < 8) ? 32'hFF : 32'h00);
      step();
    end
    chk("t2_end_valid", 32'(bus.o_row_valid), 32'h0);

    // backpressure at row 4; map row 2 = 1010
    bus.i_map = 16'h00A0;
    bus.i_map_valid = 1'b1;
    step();
    bus.i_map_valid = 1'b0;
    step();
    step();
    step();
    step();
    chk("t3_idx4", 32'(bus.o_row_idx), 32'h4);
    chk("t3_row4", 32'(bus.o_row), 32'hCC);
    bus.i_row_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("t3_hold_valid", 32'(bus.o_row_valid), 32'h1);
      chk("t3_hold_idx", 32'(bus.o_row_idx), 32'h4);
      chk("t3_hold_row", 32'(bus.o_row), 32'hCC);
      chk("t3_hold_last", 32'(bus.o_row_last), 32'h0);
    end
    bus.i_row_ready = 1'b1;
    step();
    chk("t3_idx5", 32'(bus.o_row_idx), 32'h5);
    chk("t3_row5", 32'(bus.o_row), 32'hCC);
    step();
    chk("t3_idx6", 32'(bus.o_row_idx), 32'h6);
    chk("t3_row6", 32'(bus.o_row), 32'h00);
    step();
    chk("t3_idx7", 32'(bus.o_row_idx), 32'h7);
    chk("t3_last7", 32'(bus.o_row_last), 32'h1);
    step();
    chk("t3_end_valid", 32'(bus.o_row_valid), 32'h0);

    // pending full with stalled sink, three maps offered
    bus.i_row_ready = 1'b0;
    bus.i_map = 16'hFFFF;
    bus.i_map_valid = 1'b1;
    step();
    chk("t4_ready_a", 32'(bus.o_map_ready), 32'h1);
    bus.i_map = 16'h0000;
    step();
    chk("t4_ready_b", 32'(bus.o_map_ready), 32'h0);
    chk("t4_busy_b", 32'(bus.o_busy), 32'h1);
    bus.i_map = 16'hF000;
    step();
    step();
    chk("t4_stall_ready", 32'(bus.o_map_ready), 32'h0);
    chk("t4_stall_idx", 32'(bus.o_row_idx), 32'h0);
    bus.i_row_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t4_x_ready", 32'(bus.o_map_ready), 32'h0);
      chk("t4_x_idx", 32'(bus.o_row_idx), 32'(k));
      chk("t4_x_row", 32'(bus.o_row), 32'hFF);
      step();
    end
    chk("t4_y_ready", 32'(bus.o_map_ready), 32'h1);
    chk("t4_y_idx", 32'(bus.o_row_idx), 32'h0);
    chk("t4_y_row", 32'(bus.o_row), 32'h00);
    chk("t4_y_valid", 32'(bus.o_row_valid), 32'h1);
    step();
    bus.i_map_valid = 1'b0;
    chk("t4_z_in_ready", 32'(bus.o_map_ready), 32'h0);
    chk("t4_y1_idx", 32'(bus.o_row_idx), 32'h1);
    for (int k = 0; k < 7; k++) step();
    chk("t4_z_idx", 32'(bus.o_row_idx), 32'h0);
    chk("t4_z_row", 32'(bus.o_row), 32'hFF);
    chk("t4_z_ready", 32'(bus.o_map_ready), 32'h1);
    for (int k = 0; k < 8; k++) step();
    chk("t4_end_valid", 32'(bus.o_row_valid), 32'h0);

    // new map on the row-7 beat with pending empty
    bus.i_map = 16'hFFFF;
    bus.i_map_valid = 1'b1;
    step();
    bus.i_map_valid = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("t5_last", 32'(bus.o_row_last), 32'h1);
    chk("t5_ready", 32'(bus.o_map_ready), 32'h1);
    bus.i_map = 16'h000F;
    bus.i_map_valid = 1'b1;
    step();
    bus.i_map_valid = 1'b0;
    chk("t5_valid", 32'(bus.o_row_valid), 32'h1);
    chk("t5_idx", 32'(bus.o_row_idx), 32'h0);
    chk("t5_row0", 32'(bus.o_row), 32'h00);
    for (int k = 0; k < 6; k++) step();
    chk("t5_row6", 32'(bus.o_row), 32'hFF);
    step();
    step();
    chk("t5_end_valid", 32'(bus.o_row_valid), 32'h0);

    // reset at row 3 with pending full
    bus.i_map = 16'hFFFF;
    bus.i_map_valid = 1'b1;
    step();
    bus.i_map = 16'h0F0F;
    step();
    bus.i_map_valid = 1'b0;
    step();
    step();
    chk("t6_idx3", 32'(bus.o_row_idx), 32'h3);
    chk("t6_pend", 32'(bus.o_map_ready), 32'h0);
    rst_n = 1'b0;
    step();
    chk("t6_rst_valid", 32'(bus.o_row_valid), 32'h0);
    chk("t6_rst_ready", 32'(bus.o_map_ready), 32'h0);
    chk("t6_rst_busy", 32'(bus.o_busy), 32'h0);
    chk("t6_rst_idx", 32'(bus.o_row_idx), 32'h0);
    chk("t6_rst_row", 32'(bus.o_row), 32'h0);
    chk("t6_rst_last", 32'(bus.o_row_last), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_idle_valid", 32'(bus.o_row_valid), 32'h0);
      chk("t6_idle_ready", 32'(bus.o_map_ready), 32'h1);
    end
    bus.i_map = 16'h8001;
    bus.i_map_valid = 1'b1;
    step();
    bus.i_map_valid = 1'b0;
    chk("t6_new_idx", 32'(bus.o_row_idx), 32'h0);
    chk("t6_new_row", 32'(bus.o_row), 32'hC0);
    for (int k = 0; k < 8; k++) step();
    chk("t6_end_valid", 32'(bus.o_row_valid), 32'h0);
    chk("t6_end_busy", 32'(bus.o_busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
